// File: rtl/traffic_phase_fsm.sv
// traffic_phase_fsm
//   Phase sequencer for a single-approach traffic signal. A prescaler
//   derives a 1 s tick from clk; the FSM steps RED -> GREEN -> YELLOW,
//   lets a pedestrian request shorten green once a minimum green has
//   elapsed, and supports a maintenance flashing-yellow override.
//
// Ports
//   clk       in   system clock
//   reset     in   asynchronous, active-low reset (returns to INIT)
//   ped_req   in   pedestrian push-button, asynchronous level
//   flash_en  in   maintenance flash request, asynchronous level
//   lamp      out  [2:0] active-low lamps: bit2 red, bit1 yellow, bit0 green
//   ped_walk  out  walk indication, high while in RED
//   phase     out  [1:0] 0 INIT, 1 RED, 2 GREEN, 3 YELLOW/FLASH
//   sec_left  out  [7:0] seconds remaining in phase, 0 in INIT/FLASH
module traffic_phase_fsm #(
  parameter int unsigned TICK_DIV    = 48000000,
  parameter int unsigned RED_S       = 15,
  parameter int unsigned GREEN_S     = 20,
  parameter int unsigned YELLOW_S    = 3,
  parameter int unsigned MIN_GREEN_S = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ped_req,
  input  logic       flash_en,
  output logic [2:0] lamp,
  output logic       ped_walk,
  output logic [1:0] phase,
  output logic [7:0] sec_left
);

  typedef enum logic [2:0] {
    ST_INIT,
    ST_RED,
    ST_GREEN,
    ST_YELLOW,
    ST_FLASH
  } state_t;

  localparam logic [31:0] TICK_LAST  = 32'(TICK_DIV - 1);
  localparam logic [7:0]  RED_LEN    = 8'(RED_S);
  localparam logic [7:0]  GREEN_LEN  = 8'(GREEN_S);
  localparam logic [7:0]  YELLOW_LEN = 8'(YELLOW_S);
  // Highest sec_left at which a pending pedestrian request may end green.
  localparam logic [7:0]  CUT_AT     = 8'(GREEN_S - MIN_GREEN_S + 1);

  localparam logic [2:0] LAMP_OFF    = 3'b111;
  localparam logic [2:0] LAMP_RED    = 3'b011;
  localparam logic [2:0] LAMP_GREEN  = 3'b110;
  localparam logic [2:0] LAMP_YELLOW = 3'b101;

  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        ped_pending_q, ped_pending_d;
  logic [2:0]  lamp_q, lamp_d;
  logic        ped_walk_q, ped_walk_d;
  logic [1:0]  phase_q, phase_d;
  logic [7:0]  sec_left_q, sec_left_d;

  logic ped_s1_q, ped_s2_q, ped_prev_q;
  logic flash_s1_q, flash_s2_q;

  logic tick;
  logic ped_rise;
  logic entering;

  // Synchronisers keep sampling while reset is held, so a flash request
  // present across reset release is already settled when INIT decides and
  // the block goes straight to FLASH without showing RED.
  always_ff @(posedge clk) begin
    ped_s1_q   <= ped_req;
    ped_s2_q   <= ped_s1_q;
    ped_prev_q <= ped_s2_q;
    flash_s1_q <= flash_en;
    flash_s2_q <= flash_s1_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_INIT;
      cnt_q         <= '0;
      ped_pending_q <= 1'b0;
      lamp_q        <= LAMP_OFF;
      ped_walk_q    <= 1'b0;
      phase_q       <= 2'd0;
      sec_left_q    <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      ped_pending_q <= ped_pending_d;
      lamp_q        <= lamp_d;
      ped_walk_q    <= ped_walk_d;
      phase_q       <= phase_d;
      sec_left_q    <= sec_left_d;
    end
  end

  always_comb begin
    tick     = (cnt_q == TICK_LAST);
    ped_rise = ped_s2_q & ~ped_prev_q;

    state_d = state_q;
    unique case (state_q)
      ST_INIT:   state_d = ST_RED;
      ST_RED:    if (tick && sec_left_q == 8'd1) state_d = ST_GREEN;
      ST_GREEN:  if (tick && (sec_left_q == 8'd1 ||
                              (ped_pending_q && sec_left_q <= CUT_AT)))
                   state_d = ST_YELLOW;
      ST_YELLOW: if (tick && sec_left_q == 8'd1) state_d = ST_RED;
      ST_FLASH:  if (!flash_s2_q) state_d = ST_RED;
      default:   state_d = ST_INIT;
    endcase
    if (flash_s2_q) state_d = ST_FLASH;

    entering = (state_d != state_q);
    cnt_d    = (entering || tick) ? '0 : cnt_q + 32'd1;

    // Clearing whenever the next state is RED/FLASH also swallows presses
    // made during RED.
    ped_pending_d = ped_pending_q;
    if (state_d == ST_RED || state_d == ST_FLASH) ped_pending_d = 1'b0;
    else if (ped_rise)                            ped_pending_d = 1'b1;

    lamp_d     = LAMP_OFF;
    ped_walk_d = 1'b0;
    phase_d    = 2'd0;
    sec_left_d = '0;
    unique case (state_d)
      ST_INIT: ;
      ST_RED: begin
        lamp_d     = LAMP_RED;
        ped_walk_d = 1'b1;
        phase_d    = 2'd1;
        sec_left_d = entering ? RED_LEN : (tick ? sec_left_q - 8'd1 : sec_left_q);
      end
      ST_GREEN: begin
        lamp_d     = LAMP_GREEN;
        phase_d    = 2'd2;
        sec_left_d = entering ? GREEN_LEN : (tick ? sec_left_q - 8'd1 : sec_left_q);
      end
      ST_YELLOW: begin
        lamp_d     = LAMP_YELLOW;
        phase_d    = 2'd3;
        sec_left_d = entering ? YELLOW_LEN : (tick ? sec_left_q - 8'd1 : sec_left_q);
      end
      ST_FLASH: begin
        phase_d = 2'd3;
        if (entering)  lamp_d = LAMP_YELLOW;
        else if (tick) lamp_d = lamp_q ^ 3'b010;
        else           lamp_d = lamp_q;
      end
      default: ;
    endcase
  end

  assign lamp     = lamp_q;
  assign ped_walk = ped_walk_q;
  assign phase    = phase_q;
  assign sec_left = sec_left_q;

endmodule
